mips8_controller: RTL and testbench

Multicycle control unit for the 8-bit MIPS datapath. A Moore state machine fetches each 32-bit instruction over four byte-wide memory reads, then decodes it and sequences the datapath through execute, memory and writeback steps. It also decodes ALU function codes and drives every mux select and write strobe on the datapath, including the register file, the instruction register bytes, the PC and external memory. It sits beside the datapath at the top of the processor and is the only sequential control in the core.

---
 rtl/mips8_controller.sv | 241 ++++++++++++++++++++++++
 tb/tb_mips8_controller.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mips8_controller.sv
// Multicycle Moore control unit for the 8-bit MIPS datapath: byte-serial fetch,
// decode, and execute/memory/writeback sequencing plus ALU function decode.
module mips8_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic [3:0] irwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic [1:0] pcsource,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       instr_done,
    output logic [3:0] state
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned ALU_W = 3;

    localparam logic [OP_W-1:0] OP_LB    = 6'b100000;
    localparam logic [OP_W-1:0] OP_SB    = 6'b101000;
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH1  = 4'd0,
        S_FETCH2  = 4'd1,
        S_FETCH3  = 4'd2,
        S_FETCH4  = 4'd3,
        S_DECODE  = 4'd4,
        S_MEMADR  = 4'd5,
        S_LBRD    = 4'd6,
        S_LBWR    = 4'd7,
        S_SBWR    = 4'd8,
        S_RTYPEEX = 4'd9,
        S_RTYPEWR = 4'd10,
        S_BEQEX   = 4'd11,
        S_JEX     = 4'd12,
        S_ADDIEX  = 4'd13,
        S_ADDIWR  = 4'd14
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH1;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // Next-state and Moore control decode
    always_comb begin
        state_d    = state_q;
        memread    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 4'b0000;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsource   = 2'b00;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        instr_done = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        aluop      = 2'b00;
        alucontrol = ALU_ADD;
        pcen       = 1'b0;

        case (state_q)
            S_FETCH1: begin
                memread = 1'b1;
                irwrite = 4'b0001;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
                state_d = S_FETCH2;
            end
            S_FETCH2: begin
                memread = 1'b1;
                irwrite = 4'b0010;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
                state_d = S_FETCH3;
            end
            S_FETCH3: begin
                memread = 1'b1;
                irwrite = 4'b0100;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
                state_d = S_FETCH4;
            end
            S_FETCH4: begin
                memread = 1'b1;
                irwrite = 4'b1000;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LB, OP_SB: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_J:         state_d = S_JEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default: begin
                        // unknown opcode retires here as a NOP
                        instr_done = 1'b1;
                        state_d    = S_FETCH1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LB) ? S_LBRD : S_SBWR;
            end
            S_LBRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                state_d = S_LBWR;
            end
            S_LBWR: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH1;
            end
            S_SBWR: begin
                memwrite   = 1'b1;
                iord       = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = S_RTYPEWR;
            end
            S_RTYPEWR: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH1;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                aluop      = 2'b01;
                branch     = 1'b1;
                pcsource   = 2'b01;
                instr_done = 1'b1;
                state_d    = S_FETCH1;
            end
            S_JEX: begin
                pcwrite    = 1'b1;
                pcsource   = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWR;
            end
            S_ADDIWR: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH1;
            end
            default: state_d = S_FETCH1;
        endcase

        // Reset presents FETCH1 decode with every strobe suppressed
        if (reset) begin
            memread    = 1'b0;
            memwrite   = 1'b0;
            iord       = 1'b0;
            irwrite    = 4'b0000;
            alusrca    = 1'b0;
            alusrcb    = 2'b01;
            pcsource   = 2'b00;
            regwrite   = 1'b0;
            regdst     = 1'b0;
            memtoreg   = 1'b0;
            instr_done = 1'b0;
            pcwrite    = 1'b0;
            branch     = 1'b0;
            aluop      = 2'b00;
        end

        case (aluop)
            2'b01:   alucontrol = ALU_SUB;
            2'b10: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase

        pcen = pcwrite | (branch & zero);
    end

endmodule

// File: tb/tb_mips8_controller.sv
// Self-checking bench for mips8_controller: directed plan plus random instruction
// streams with random reset aborts, compared each cycle against a per-instruction step model.
module tb_mips8_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       memread, memwrite, iord, alusrca, pcen, regwrite, regdst, memtoreg, instr_done;
    logic [3:0] irwrite, state;
    logic [1:0] alusrcb, pcsource;
    logic [2:0] alucontrol;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [5:0] LB = 6'b100000, SB = 6'b101000, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

    mips8_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
        .pcsource(pcsource), .pcen(pcen), .regwrite(regwrite), .regdst(regdst),
        .memtoreg(memtoreg), .instr_done(instr_done), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [19:0] obs;
    assign obs = {memread, memwrite, iord, irwrite, alusrca, alusrcb, alucontrol,
                  pcsource, pcen, regwrite, regdst, memtoreg, instr_done};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ilen(input logic [5:0] o);
        case (o)
            LB:           return 8;
            SB, RT, ADDI: return 7;
            BEQ, JMP:     return 6;
            default:      return 5;
        endcase
    endfunction

    function automatic logic [2:0] alu_ref(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected controls for step k of an instruction (k=0 is FETCH1)
    function automatic logic [19:0] exp_ctrl(input logic [5:0] o, input logic [5:0] f,
                                             input logic z, input int k, input logic rst);
        logic mr, mw, io, sa, pe, rw, rd, mt, dn;
        logic [3:0] ir;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        mr = 0; mw = 0; io = 0; sa = 0; pe = 0; rw = 0; rd = 0; mt = 0; dn = 0;
        ir = 4'd0; sb = 2'b00; ps = 2'b00; ac = 3'b010;
        if (rst) begin
            sb = 2'b01;
        end else if (k < 4) begin
            mr = 1; ir = 4'(1 << k); sb = 2'b01; pe = 1;
        end else if (k == 4) begin
            sb = 2'b11;
            dn = (ilen(o) == 5);
        end else begin
            case (o)
                LB: if (k == 5) begin sa = 1; sb = 2'b10; end
                    else if (k == 6) begin mr = 1; io = 1; end
                    else begin rw = 1; mt = 1; dn = 1; end
                SB: if (k == 5) begin sa = 1; sb = 2'b10; end
                    else begin mw = 1; io = 1; dn = 1; end
                RT: if (k == 5) begin sa = 1; ac = alu_ref(f); end
                    else begin rd = 1; rw = 1; dn = 1; end
                BEQ: begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; dn = 1; end
                JMP: begin pe = 1; ps = 2'b10; dn = 1; end
                ADDI: if (k == 5) begin sa = 1; sb = 2'b10; end
                      else begin rw = 1; dn = 1; end
                default: ;
            endcase
        end
        return {mr, mw, io, ir, sa, sb, ac, ps, pe, rw, rd, mt, dn};
    endfunction

    task automatic cycle(input logic rst, input logic [5:0] o, input logic [5:0] f, input logic z);
        @(posedge clk);
        #1;
        reset = rst; op = o; funct = f; zero = z;
        @(negedge clk);
    endtask

    // zmode 0/1 forces zero, 2 randomizes it; abort_at<0 runs to completion
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode, input int abort_at);
        int n;
        logic z, rst;
        logic [5:0] od, fd;
        n = ilen(o);
        for (int k = 0; k < n; k++) begin
            z   = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            od  = (k < 3) ? 6'($urandom) : o;
            fd  = (k < 3) ? 6'($urandom) : f;
            rst = (k == abort_at);
            cycle(rst, od, fd, z);
            check($sformatf("ctl op=%b fn=%b k=%0d rst=%0d", o, f, k, rst), 32'(obs),
                  32'(exp_ctrl(od, fd, z, k, rst)));
            if (k == 0)
                check($sformatf("state_fetch1 op=%b", o), 32'(state), 32'd0);
            else if (!rst)
                check($sformatf("state_nonzero op=%b k=%0d", o, k), 32'(state != 4'd0), 32'd1);
            if (rst) break;
        end
    endtask

    initial begin
        logic [5:0] ops[6];
        logic [5:0] fns[5];
        logic [5:0] o, f;
        int ab;
        ops = '{LB, SB, RT, BEQ, JMP, ADDI};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 6'($urandom), 6'($urandom), 1'($urandom));
            check("reset_state", 32'(state), 32'd0);
            check("reset_ctl", 32'(obs), 32'(exp_ctrl(6'd0, 6'd0, 1'b0, 0, 1'b1)));
        end

        run_instr(LB, 6'b100000, 2, -1);
        run_instr(RT, 6'b100010, 2, -1);
        run_instr(RT, 6'b101010, 2, -1);
        run_instr(BEQ, 6'd0, 1, -1);
        run_instr(BEQ, 6'd0, 0, -1);
        run_instr(JMP, 6'd0, 2, -1);
        run_instr(ADDI, 6'd0, 2, -1);
        run_instr(6'b111111, 6'd0, 2, -1);
        run_instr(SB, 6'd0, 2, 5);
        run_instr(SB, 6'd0, 2, -1);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 6) == 6) o = 6'($urandom);
            else o = ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 5) == 5) f = 6'($urandom);
            else f = fns[$urandom_range(0, 4)];
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, ilen(o) - 1)) : -1;
            run_instr(o, f, 2, ab);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
